// File: rtl/mdu_iter_divider_pkg.sv
// Processor-wide constants shared by the ALU, control unit and divider.
// Holds SELECT op codes, the divider state encoding and the default width.
package mdu_iter_divider_pkg;

    localparam int MDU_DATA_WIDTH = 32;

    localparam logic [4:0] SEL_DIV  = 5'b01100;
    localparam logic [4:0] SEL_REM  = 5'b01101;
    localparam logic [4:0] SEL_DIVU = 5'b01110;
    localparam logic [4:0] SEL_REMU = 5'b01111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_ADJUST,
        ST_FINISH
    } div_state_t;

    function automatic logic is_div_sel(input logic [4:0] sel);
        return (sel == SEL_DIV) || (sel == SEL_REM) ||
               (sel == SEL_DIVU) || (sel == SEL_REMU);
    endfunction

endpackage

// File: rtl/mdu_iter_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract.
// The shifted remainder carries an extra MSB so divisors >= 2^(W-1) work.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic         msb,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);

    logic [W:0] trial;

    always_comb begin
        trial    = {rem, msb};
        q_bit    = (trial >= {1'b0, divisor});
        // Difference is below divisor, so the low W bits are exact.
        rem_next = q_bit ? (trial[W-1:0] - divisor) : trial[W-1:0];
    end

endmodule

// File: rtl/mdu_iter_divider.sv
// Iterative radix-2 DIV/DIVU/REM/REMU unit for the EX stage.
// Stalls via BUSY, then pulses DONE with RESULT for the EX/MEM register.
module mdu_iter_divider
    import mdu_iter_divider_pkg::*;
#(
    parameter int DATA_WIDTH = MDU_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic                  FLUSH,
    input  logic [4:0]            SELECT,
    input  logic [DATA_WIDTH-1:0] DATA1,
    input  logic [DATA_WIDTH-1:0] DATA2,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] RESULT
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    div_state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] rem_q, dvd_q, dvs_q, result_q;
    logic [CW-1:0]         cnt_q;
    logic                  q_neg_q, r_neg_q, want_rem_q;

    logic                  sel_ok, sel_signed, sel_rem;
    logic                  div_zero, sgn_ovf, special, accept;
    logic [DATA_WIDTH-1:0] abs1, abs2, special_res, adj_res;
    logic [DATA_WIDTH-1:0] step_rem;
    logic                  step_q;

    always_comb begin
        sel_ok     = is_div_sel(SELECT);
        sel_signed = (SELECT == SEL_DIV) || (SELECT == SEL_REM);
        sel_rem    = (SELECT == SEL_REM) || (SELECT == SEL_REMU);
        div_zero   = (DATA2 == '0);
        sgn_ovf    = sel_signed && (DATA1 == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                     && (DATA2 == '1);
        special    = div_zero || sgn_ovf;
        accept     = (state == ST_IDLE) && START && sel_ok && !FLUSH;
        // Negating the most negative value yields 2^(W-1) read as unsigned.
        abs1 = (sel_signed && DATA1[DATA_WIDTH-1]) ? -DATA1 : DATA1;
        abs2 = (sel_signed && DATA2[DATA_WIDTH-1]) ? -DATA2 : DATA2;
        if (div_zero)
            special_res = sel_rem ? DATA1 : '1;
        else
            special_res = sel_rem ? '0 : DATA1;
    end

    always_comb begin
        adj_res = '0;
        if (want_rem_q)
            adj_res = r_neg_q ? -rem_q : rem_q;
        else
            adj_res = q_neg_q ? -dvd_q : dvd_q;
    end

    div_step #(
        .W (DATA_WIDTH)
    ) u_step (
        .rem      (rem_q),
        .msb      (dvd_q[DATA_WIDTH-1]),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge CLK) begin
        if (RESET)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept)
                    state_nxt = special ? ST_FINISH : ST_CALC;
            end
            ST_CALC: begin
                BUSY = 1'b1;
                if (FLUSH)
                    state_nxt = ST_IDLE;
                else if (cnt_q == CW'(1))
                    state_nxt = ST_ADJUST;
            end
            ST_ADJUST: begin
                BUSY      = 1'b1;
                state_nxt = FLUSH ? ST_IDLE : ST_FINISH;
            end
            ST_FINISH: begin
                DONE      = !FLUSH;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Dividend register doubles as the quotient as bits shift in.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            want_rem_q <= 1'b0;
        end else if (accept) begin
            if (special) begin
                result_q <= special_res;
            end else begin
                rem_q      <= '0;
                dvd_q      <= abs1;
                dvs_q      <= abs2;
                cnt_q      <= CW'(DATA_WIDTH);
                q_neg_q    <= sel_signed &&
                              (DATA1[DATA_WIDTH-1] ^ DATA2[DATA_WIDTH-1]);
                r_neg_q    <= sel_signed && DATA1[DATA_WIDTH-1];
                want_rem_q <= sel_rem;
            end
        end else if (state == ST_CALC && !FLUSH) begin
            rem_q <= step_rem;
            dvd_q <= {dvd_q[DATA_WIDTH-2:0], step_q};
            cnt_q <= cnt_q - 1'b1;
        end else if (state == ST_ADJUST && !FLUSH) begin
            result_q <= adj_res;
        end
    end

    assign RESULT = result_q;

endmodule

// File: tb/tb_mdu_iter_divider.sv
// Directed and random checks of mdu_iter_divider against an arithmetic model.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mdu_iter_divider;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        FLUSH = 1'b0;
    logic [4:0]  SELECT = 5'b0;
    logic [31:0] DATA1 = '0;
    logic [31:0] DATA2 = '0;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;

    int n_checks = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    mdu_iter_divider dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .FLUSH  (FLUSH),
        .SELECT (SELECT),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    function automatic logic [31:0] model(input logic [4:0] sel,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (sel)
            5'b01100: begin
                if (b == 0) return 32'hFFFFFFFF;
                q = sa / sb;
                return q[31:0];
            end
            5'b01101: begin
                if (b == 0) return a;
                r = sa % sb;
                return r[31:0];
            end
            5'b01110: return (b == 0) ? 32'hFFFFFFFF : a / b;
            5'b01111: return (b == 0) ? a : a % b;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic bit is_special(input logic [4:0] sel,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        if (b == 0) return 1'b1;
        return (sel == 5'b01100 || sel == 5'b01101) &&
               a == 32'h80000000 && b == 32'hFFFFFFFF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issues one op and follows it until DONE or a 40-cycle bound.
    task automatic run_op(input logic [4:0] sel, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output int done_at, output int busy_cnt);
        SELECT = sel;
        DATA1 = a;
        DATA2 = b;
        START = 1'b1;
        tick();
        START = 1'b0;
        done_at = 0;
        busy_cnt = 0;
        res = 'x;
        for (int k = 1; k <= 40; k++) begin
            if (BUSY) busy_cnt++;
            if (DONE) begin
                done_at = k;
                res = RESULT;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic do_op(input string tag, input logic [4:0] sel,
                         input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        int done_at, busy_cnt;
        bit sp;
        sp = is_special(sel, a, b);
        run_op(sel, a, b, res, done_at, busy_cnt);
        check({tag, "_result"}, res, model(sel, a, b));
        check({tag, "_done_at"}, done_at, sp ? 1 : 34);
        check({tag, "_busy_cycles"}, busy_cnt, sp ? 0 : 33);
    endtask

    task automatic watch(input int n, output int dones, output int busys);
        dones = 0;
        busys = 0;
        for (int k = 0; k < n; k++) begin
            if (DONE) dones++;
            if (BUSY) busys++;
            tick();
        end
    endtask

    initial begin
        logic [4:0] sels [4];
        logic [31:0] a, b;
        int dones, busys, first_done;
        logic [31:0] first_res;

        sels[0] = 5'b01100;
        sels[1] = 5'b01101;
        sels[2] = 5'b01110;
        sels[3] = 5'b01111;

        tick();
        tick();
        tick();
        RESET = 1'b0;
        check("reset_busy", BUSY, 0);
        check("reset_done", DONE, 0);
        check("reset_result", RESULT, 0);

        do_op("divu_100_7", 5'b01110, 100, 7);
        do_op("remu_100_7", 5'b01111, 100, 7);
        do_op("div_m20_3", 5'b01100, 32'hFFFFFFEC, 3);
        do_op("rem_m20_3", 5'b01101, 32'hFFFFFFEC, 3);
        do_op("div_5_0", 5'b01100, 5, 0);
        do_op("remu_5_0", 5'b01111, 5, 0);
        do_op("div_ovf", 5'b01100, 32'h80000000, 32'hFFFFFFFF);
        do_op("rem_ovf", 5'b01101, 32'h80000000, 32'hFFFFFFFF);
        do_op("divu_min_m1", 5'b01110, 32'h80000000, 32'hFFFFFFFF);
        do_op("div_min_2", 5'b01100, 32'h80000000, 2);

        // Second START mid-operation must be ignored.
        SELECT = 5'b01110;
        DATA1 = 32'hFFFFFFFF;
        DATA2 = 1;
        START = 1'b1;
        tick();
        START = 1'b0;
        dones = 0;
        first_done = 0;
        first_res = '0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 10) begin
                DATA1 = 9;
                DATA2 = 3;
                START = 1'b1;
            end
            if (k == 11) START = 1'b0;
            if (DONE) begin
                dones++;
                if (first_done == 0) begin
                    first_done = k;
                    first_res = RESULT;
                end
            end
            tick();
        end
        check("restart_done_count", dones, 1);
        check("restart_done_at", first_done, 34);
        check("restart_result", first_res, 32'hFFFFFFFF);
        do_op("divu_9_3", 5'b01110, 9, 3);

        // FLUSH at t+15 aborts; RESULT keeps the previous value.
        SELECT = 5'b01110;
        DATA1 = 100;
        DATA2 = 7;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int k = 1; k < 15; k++) tick();
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        check("flush_busy_next", BUSY, 0);
        watch(40, dones, busys);
        check("flush_no_done", dones, 0);
        check("flush_result_kept", RESULT, 3);

        FLUSH = 1'b1;
        START = 1'b1;
        tick();
        FLUSH = 1'b0;
        START = 1'b0;
        watch(40, dones, busys);
        check("flush_start_busy", busys, 0);
        check("flush_start_done", dones, 0);

        // RESET at t+20 mid-operation.
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int k = 1; k < 20; k++) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("midreset_busy", BUSY, 0);
        check("midreset_done", DONE, 0);
        check("midreset_result", RESULT, 0);
        watch(40, dones, busys);
        check("midreset_no_done", dones, 0);

        SELECT = 5'b00000;
        DATA1 = 50;
        DATA2 = 5;
        START = 1'b1;
        tick();
        START = 1'b0;
        watch(40, dones, busys);
        check("badsel_busy", busys, 0);
        check("badsel_done", dones, 0);

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            case ($urandom_range(0, 5))
                0: b = 0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFFFFFF;
                3: b = $urandom;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            do_op($sformatf("rand%0d", i), sels[$urandom_range(0, 3)], a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
